// File: rtl/sys_cmd_engine_if.sv
// Byte-stream interface between the UART rx/tx adapters and the command engine.
// The master side is the UART side and the slave side is the engine.
interface sys_cmd_engine_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output rx_data, rx_valid, tx_ready, input tx_data, tx_valid);
    modport slave  (input rx_data, rx_valid, tx_ready, output tx_data, tx_valid);
endinterface

// File: rtl/sys_cmd_engine.sv
// MCU command decoder and response/joypad-report transmitter.
// The RX FSM parses commands. The TX FSM sends atomic messages from a byte shift register.
module sys_cmd_engine #(
    parameter int unsigned FREQ            = 21_477_000,
    parameter logic [15:0] CORE_ID         = 16'd1,
    parameter int unsigned N_JOY           = 2,
    parameter int unsigned JOY_W           = 12,
    parameter int unsigned CFG_BYTES       = 4,
    parameter int unsigned LEN_BYTES       = 3,
    parameter int unsigned STR_LEN         = 9,
    parameter logic [STR_LEN*8-1:0] CONF_STR = "Tangcores",
    parameter int unsigned REPORT_INTERVAL = 429_540,
    parameter int unsigned TIMEOUT         = 2_147_700
) (
    input  logic                   clk,
    input  logic                   reset,
    sys_cmd_engine_if.slave        bus,
    input  logic [N_JOY*JOY_W-1:0] joy,
    output logic [7:0]             rom_loading,
    output logic [7:0]             rom_do,
    output logic                   rom_do_valid,
    output logic [CFG_BYTES*8-1:0] core_config,
    output logic                   overlay,
    output logic                   err_timeout,
    output logic                   err_overrun
);
    localparam int unsigned JOY_BYTES   = (JOY_W + 7) / 8;
    localparam int unsigned PAD_W       = JOY_BYTES * 8;
    localparam int unsigned REP_LEN     = 1 + N_JOY * JOY_BYTES;
    localparam int unsigned STR_MSG_LEN = STR_LEN + 2;
    localparam int unsigned MSG_BYTES   = (REP_LEN > STR_MSG_LEN) ? REP_LEN : STR_MSG_LEN;
    localparam int unsigned MSG_W       = MSG_BYTES * 8;
    localparam int unsigned CFG_W       = CFG_BYTES * 8;
    localparam int unsigned LEN_W       = LEN_BYTES * 8;
    localparam int unsigned TO_W        = $clog2(TIMEOUT + 1);
    localparam int unsigned RI_W        = (REPORT_INTERVAL > 1) ? $clog2(REPORT_INTERVAL) : 1;

    if (N_JOY < 1 || N_JOY > 4 || FREQ == 0) begin : g_param_check
        $error("sys_cmd_engine: unsupported parameter set");
    end

    typedef enum logic [1:0] {RX_IDLE, RX_PARAM, RX_RESP_WAIT} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    rx_state_t rx_state, rx_next;
    tx_state_t tx_state, tx_next;

    logic [7:0]       opcode, pcnt, sum;
    logic             data_phase, report_mode;
    logic [LEN_W-1:0] remain, len_shift, len_new;
    logic [CFG_W-1:0] cfg_shift, cfg_new;
    logic [TO_W-1:0]  gap;
    logic             resp_req, param_done, timeout_hit, overrun;

    logic             tx_on, cur_rep, resp_pend, report_due;
    logic [MSG_W-1:0] msg, rep_msg, resp_msg;
    logic [7:0]       rem, resp_len;
    logic [N_JOY*JOY_W-1:0] last_sent;
    logic [RI_W-1:0]  per_cnt;
    logic             per_wrap, start_resp, start_rep, shift, resp_done;

    assign bus.tx_valid = tx_on;
    assign bus.tx_data  = msg[7:0];
    assign per_wrap     = (per_cnt == RI_W'(REPORT_INTERVAL - 1));

    // RX command FSM
    always_ff @(posedge clk) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next     = rx_state;
        resp_req    = 1'b0;
        param_done  = 1'b0;
        timeout_hit = 1'b0;
        overrun     = 1'b0;
        len_new     = LEN_W'({len_shift, bus.rx_data});
        cfg_new     = CFG_W'({cfg_shift, bus.rx_data});
        case (rx_state)
            RX_IDLE: begin
                if (bus.rx_valid) begin
                    case (bus.rx_data)
                        8'd1, 8'd2: begin
                            resp_req = 1'b1;
                            rx_next  = RX_RESP_WAIT;
                        end
                        8'd3, 8'd6, 8'd7, 8'd8, 8'd9: rx_next = RX_PARAM;
                        default: ;
                    endcase
                end
            end
            RX_PARAM: begin
                if (bus.rx_valid) begin
                    case (opcode)
                        8'd3: param_done = (pcnt == 8'(CFG_BYTES - 1));
                        8'd7: begin
                            if (!data_phase)
                                resp_req = (pcnt == 8'(LEN_BYTES - 1)) && (len_new == '0);
                            else
                                resp_req = (remain == LEN_W'(1));
                        end
                        default: param_done = 1'b1;
                    endcase
                    if (resp_req)        rx_next = RX_RESP_WAIT;
                    else if (param_done) rx_next = RX_IDLE;
                end else if (gap == TO_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    rx_next     = RX_IDLE;
                end
            end
            RX_RESP_WAIT: begin
                overrun = bus.rx_valid;
                if (resp_done) rx_next = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // RX datapath: parameter collection and command side effects
    always_ff @(posedge clk) begin
        if (reset) begin
            opcode       <= '0;
            pcnt         <= '0;
            sum          <= '0;
            data_phase   <= 1'b0;
            report_mode  <= 1'b0;
            remain       <= '0;
            len_shift    <= '0;
            cfg_shift    <= '0;
            gap          <= '0;
            rom_loading  <= '0;
            rom_do       <= '0;
            rom_do_valid <= 1'b0;
            core_config  <= '0;
            overlay      <= 1'b1;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            err_timeout  <= timeout_hit;
            err_overrun  <= overrun;
            rom_do_valid <= 1'b0;
            gap <= (rx_state == RX_PARAM && !bus.rx_valid) ? gap + TO_W'(1) : '0;
            if (rx_state == RX_IDLE && bus.rx_valid) begin
                opcode     <= bus.rx_data;
                pcnt       <= '0;
                data_phase <= 1'b0;
                sum        <= '0;
            end
            if (rx_state == RX_PARAM && bus.rx_valid) begin
                pcnt <= pcnt + 8'd1;
                case (opcode)
                    8'd3: begin
                        cfg_shift <= cfg_new;
                        if (param_done) core_config <= cfg_new;
                    end
                    8'd6: rom_loading <= bus.rx_data;
                    8'd8: overlay     <= bus.rx_data[0];
                    8'd9: report_mode <= bus.rx_data[0];
                    8'd7: begin
                        if (!data_phase) begin
                            len_shift <= len_new;
                            if (pcnt == 8'(LEN_BYTES - 1)) begin
                                data_phase <= 1'b1;
                                remain     <= len_new;
                            end
                        end else begin
                            rom_do       <= bus.rx_data;
                            rom_do_valid <= 1'b1;
                            sum          <= sum + bus.rx_data;
                            remain       <= remain - LEN_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Message images, byte 0 in the LSBs
    always_comb begin
        rep_msg      = '0;
        rep_msg[7:0] = 8'h01;
        for (int p = 0; p < N_JOY; p++)
            rep_msg[8 + p*PAD_W +: PAD_W] = PAD_W'(joy[p*JOY_W +: JOY_W]);
        resp_msg = '0;
        resp_len = 8'd2;
        case (opcode)
            8'd1: begin
                resp_msg[23:0] = {CORE_ID[15:8], CORE_ID[7:0], 8'h11};
                resp_len       = 8'd3;
            end
            8'd2: begin
                resp_msg[7:0] = 8'h22;
                for (int i = 0; i < STR_LEN; i++)
                    resp_msg[8 + i*8 +: 8] = CONF_STR[(STR_LEN - 1 - i)*8 +: 8];
                resp_len = 8'(STR_MSG_LEN);
            end
            default: resp_msg[15:0] = {sum, 8'h77};
        endcase
    end

    // TX FSM: responses take priority over reports at message boundaries
    always_ff @(posedge clk) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_next;
    end

    always_comb begin
        tx_next    = tx_state;
        start_resp = 1'b0;
        start_rep  = 1'b0;
        shift      = 1'b0;
        resp_done  = 1'b0;
        if (!tx_on || bus.tx_ready) begin
            if (tx_state == TX_SEND && rem > 8'd1) begin
                shift = 1'b1;
            end else begin
                resp_done = (tx_state == TX_SEND) && !cur_rep;
                if (resp_pend) begin
                    start_resp = 1'b1;
                    tx_next    = TX_SEND;
                end else if (report_due) begin
                    start_rep = 1'b1;
                    tx_next   = TX_SEND;
                end else begin
                    tx_next = TX_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_on      <= 1'b0;
            msg        <= '0;
            rem        <= '0;
            cur_rep    <= 1'b0;
            resp_pend  <= 1'b0;
            report_due <= 1'b0;
            last_sent  <= '0;
            per_cnt    <= '0;
        end else begin
            per_cnt <= per_wrap ? '0 : per_cnt + RI_W'(1);
            if (start_resp || start_rep) begin
                msg     <= start_rep ? rep_msg : resp_msg;
                rem     <= start_rep ? 8'(REP_LEN) : resp_len;
                cur_rep <= start_rep;
                tx_on   <= 1'b1;
            end else if (shift) begin
                msg <= msg >> 8;
                rem <= rem - 8'd1;
            end else if (bus.tx_ready) begin
                tx_on <= 1'b0;
            end
            if (resp_req)        resp_pend <= 1'b1;
            else if (start_resp) resp_pend <= 1'b0;
            // Starting a report consumes every trigger seen up to this cycle
            if (start_rep) begin
                report_due <= 1'b0;
                last_sent  <= joy;
            end else if (per_wrap || (report_mode && joy != last_sent)) begin
                report_due <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sys_cmd_engine.sv
// Directed bench for sys_cmd_engine with short interval/timeout parameters.
// A negedge monitor splits TX traffic into report and response streams.
module tb_sys_cmd_engine;
    localparam int RI = 3000;
    localparam int TO = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] joy;
    logic [7:0]  rom_loading, rom_do;
    logic        rom_do_valid, overlay, err_timeout, err_overrun;
    logic [31:0] core_config;

    sys_cmd_engine_if bus();

    sys_cmd_engine #(.REPORT_INTERVAL(RI), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .bus(bus), .joy(joy),
        .rom_loading(rom_loading), .rom_do(rom_do), .rom_do_valid(rom_do_valid),
        .core_config(core_config), .overlay(overlay),
        .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rdy_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0)      bus.tx_ready = 1'b1;
        else if (rdy_mode == 1) bus.tx_ready = ~bus.tx_ready;
        else                    bus.tx_ready = 1'b0;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // TX / strobe monitor
    int          mpos = 0, mlen = 1, rep_cnt = 0, rep_time = 0, rep_start = 0;
    int          to_cnt = 0, ov_cnt = 0, stall_err = 0;
    logic [7:0]  hdr = 8'h00, stall_data = 8'h00;
    logic        stall_prev = 1'b0;
    logic [39:0] rep_acc = '0, rep_last = '0;
    logic [7:0]  resp_q[$], hdr_q[$], rom_q[$];

    always @(negedge clk) begin
        if (reset) begin
            mpos = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && !(bus.tx_valid && bus.tx_data == stall_data)) stall_err++;
            stall_prev = bus.tx_valid && !bus.tx_ready;
            stall_data = bus.tx_data;
            if (bus.tx_valid && bus.tx_ready) begin
                if (mpos == 0) begin
                    hdr = bus.tx_data;
                    case (hdr)
                        8'h01:   mlen = 5;
                        8'h11:   mlen = 3;
                        8'h22:   mlen = 11;
                        8'h77:   mlen = 2;
                        default: mlen = 1;
                    endcase
                    hdr_q.push_back(hdr);
                    if (hdr == 8'h01) begin
                        rep_start = cyc;
                        rep_acc = '0;
                    end
                end
                if (hdr == 8'h01) rep_acc = {bus.tx_data, rep_acc[39:8]};
                else              resp_q.push_back(bus.tx_data);
                mpos++;
                if (mpos == mlen) begin
                    mpos = 0;
                    if (hdr == 8'h01) begin
                        rep_cnt++;
                        rep_last = rep_acc;
                        rep_time = rep_start;
                    end
                end
            end
            if (err_timeout)  to_cnt++;
            if (err_overrun)  ov_cnt++;
            if (rom_do_valid) rom_q.push_back(rom_do);
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_resp(input int n, input int budget);
        while (resp_q.size() < n && budget > 0) begin
            @(posedge clk);
            budget--;
        end
    endtask

    task automatic take_resp(input int n, output logic [63:0] v);
        v = '0;
        for (int i = 0; i < n; i++)
            v = {v[55:0], (resp_q.size() > 0) ? resp_q.pop_front() : 8'hEE};
    endtask

    task automatic wait_report(input int n0, input int budget);
        while (rep_cnt <= n0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
    endtask

    initial begin
        logic [63:0] v;
        string       s;
        int          t_ref, tc, k, n0, cnt22;
        s = "Tangcores";
        reset = 1'b1;
        joy = '0;
        bus.rx_data = '0;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_overlay", overlay, 1);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_core_config", core_config, 0);
        check("rst_rom_loading", rom_loading, 0);
        check("rst_errs", {err_timeout, err_overrun, rom_do_valid}, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // first periodic report, idle link, joy = 0
        wait_report(0, RI + 100);
        check("periodic_first_seen", rep_cnt, 1);
        check("periodic_first_bytes", rep_last, 40'h00_0000_0001);
        t_ref = rep_time;

        // core ID
        resp_q.delete();
        send(8'h01);
        wait_resp(3, 50);
        check("coreid_len", resp_q.size(), 3);
        take_resp(3, v);
        check("coreid_bytes", v, 64'h110100);
        send(8'h06); send(8'h5A);
        @(negedge clk);
        check("rom_loading", rom_loading, 8'h5A);

        // config string under backpressure
        rdy_mode = 1;
        send(8'h02);
        wait_resp(11, 200);
        repeat (30) @(posedge clk);
        check("string_len_once", resp_q.size(), 11);
        for (int i = 0; i < 11; i++) begin
            logic [7:0] e;
            e = (i == 0) ? 8'h22 : (i == 10) ? 8'h00 : 8'(s[i-1]);
            check($sformatf("string_byte%0d", i), (resp_q.size() > i) ? resp_q[i] : 8'hEE, e);
        end
        check("stall_stable", stall_err, 0);
        resp_q.delete();
        rdy_mode = 0;

        // ROM load with checksum
        rom_q.delete();
        send(8'h07); send(8'h00); send(8'h00); send(8'h03);
        send(8'h10); send(8'h20); send(8'hF5);
        wait_resp(2, 50);
        check("rom_strobes", rom_q.size(), 3);
        v = '0;
        for (int i = 0; i < rom_q.size() && i < 3; i++) v = {v[55:0], rom_q[i]};
        check("rom_bytes", v, 64'h1020F5);
        take_resp(2, v);
        check("rom_ack", v, 64'h7725);

        // zero-length ROM load
        rom_q.delete();
        send(8'h07); send(8'h00); send(8'h00); send(8'h00);
        wait_resp(2, 50);
        take_resp(2, v);
        check("rom0_ack", v, 64'h7700);
        check("rom0_no_strobe", rom_q.size(), 0);

        // inter-byte timeout on a partial config word
        send(8'h03); send(8'hAA); send(8'hBB);
        k = 0;
        while (to_cnt == 0 && k < TO + 20) begin
            @(posedge clk);
            k++;
        end
        check("timeout_latency", k, TO + 1);
        check("timeout_pulses", to_cnt, 1);
        check("timeout_cfg_kept", core_config, 0);
        send(8'h08); send(8'h00);
        @(negedge clk);
        check("overlay_off", overlay, 0);

        // full config word; intermediate bytes must not show
        send(8'h03); send(8'h12); send(8'h34); send(8'h56);
        @(negedge clk);
        check("cfg_partial", core_config, 0);
        send(8'h78);
        @(negedge clk);
        check("cfg_full", core_config, 32'h1234_5678);
        check("no_stray_resp", resp_q.size(), 0);

        // on-change reporting, then periodic phase preserved
        send(8'h09); send(8'h01);
        while (((cyc - t_ref) % RI) < 100 || ((cyc - t_ref) % RI) > RI - 100) @(posedge clk);
        n0 = rep_cnt;
        @(posedge clk); #1;
        joy = 24'h000001;
        tc = cyc;
        wait_report(n0, 20);
        check("onchange_seen", rep_cnt, n0 + 1);
        check("onchange_fast", (rep_time - tc >= 1) && (rep_time - tc <= 4), 1);
        check("onchange_bytes", rep_last, 40'h00_0000_0101);
        n0 = rep_cnt;
        wait_report(n0, RI + 100);
        check("periodic_next_seen", rep_cnt, n0 + 1);
        check("periodic_phase", (rep_time - t_ref) % RI, 0);

        // report in flight, then a command and an overrun byte
        rdy_mode = 2;
        while (((cyc - t_ref) % RI) < 100 || ((cyc - t_ref) % RI) > RI - 100) @(posedge clk);
        @(posedge clk); #1;
        joy = 24'h000002;
        repeat (5) @(posedge clk);
        send(8'h01);
        send(8'h55);
        repeat (2) @(posedge clk);
        check("overrun_pulse", ov_cnt, 1);
        hdr_q.delete();
        resp_q.delete();
        n0 = rep_cnt;
        rdy_mode = 0;
        wait_resp(3, 50);
        check("arb_order", {(hdr_q.size() > 0) ? hdr_q[0] : 8'hEE,
                            (hdr_q.size() > 1) ? hdr_q[1] : 8'hEE}, 16'h0111);
        check("arb_report_bytes", rep_last, 40'h00_0000_0201);
        take_resp(3, v);
        check("arb_resp", v, 64'h110100);

        // reset while a message is stalled
        rdy_mode = 2;
        hdr_q.delete();
        send(8'h02);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midmsg_valid", bus.tx_valid, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midmsg_reset_valid", bus.tx_valid, 0);
        check("midmsg_reset_overlay", overlay, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        rdy_mode = 0;
        repeat (40) @(posedge clk);
        cnt22 = 0;
        foreach (hdr_q[i]) if (hdr_q[i] == 8'h22) cnt22++;
        check("midmsg_abandoned", cnt22, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sys_cmd_engine.md
Name: sys_cmd_engine

Overview:
- Parametrised command/response engine between the UART byte stream from the companion MCU and the core.
- Decodes MCU commands: core ID, config string, config word, ROM streaming, loading state, overlay enable and report mode.
- Sends periodic or on-change joypad reports for N_JOY pads.
- Sits between the uart_rx/uart_tx byte interfaces and core logic.
- New over the previous generation:
  - valid/ready TX handshake.
  - Any pad count and width.
  - On-change reporting.
  - Inter-byte command timeout.
  - ROM-load checksum acknowledge.

Parameters:
- FREQ, 21_477_000, clk frequency in Hz (documentation only; intervals are given in cycles).
- CORE_ID, 16'd1, returned by command 1.
- N_JOY, 2, number of joypads reported (1..4).
- JOY_W, 12, bits per joypad; JOY_BYTES = ceil(JOY_W/8), zero-padded.
- CFG_BYTES, 4, width of core_config in bytes.
- LEN_BYTES, 3, ROM length field in bytes.
- STR_LEN, 9, config string length in characters.
- CONF_STR, "Tangcores", config string, first character in the MSBs.
- REPORT_INTERVAL, 429_540, cycles between periodic joypad reports (20 ms at FREQ).
- TIMEOUT, 2_147_700, maximum idle cycles between parameter bytes (100 ms).

Ports:
- clk  in  1  main logic clock.
- reset  in  1  synchronous, active-high.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe qualifying rx_data.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  transmit request.
- tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready.
- joy  in  N_JOY*JOY_W  pad states, pad 0 in the LSBs.
- rom_loading  out  8  loading state.
- rom_do  out  8  ROM data byte.
- rom_do_valid  out  1  one-cycle strobe qualifying rom_do.
- core_config  out  CFG_BYTES*8  config word.
- overlay  out  1  OSD overlay enable.
- err_timeout  out  1  one-cycle pulse when a command is aborted on timeout.
- err_overrun  out  1  one-cycle pulse when an rx byte is dropped.

Behaviour:
- Reset values:
  - overlay=1.
  - All other outputs, report_mode, counters and flags = 0.
  - RX FSM in IDLE, TX FSM in IDLE.
- Commands (parameters MSB-first):
  - 1: respond 0x11, CORE_ID[7:0], CORE_ID[15:8].
  - 2: respond 0x22, CONF_STR characters, 0x00.
  - 3: CFG_BYTES bytes. core_config updates in the cycle after the last byte; intermediate bytes do not change it.
  - 6: 1 byte, written to rom_loading.
  - 7: LEN_BYTES length, then length data bytes.
    - Each data byte drives rom_do with rom_do_valid high 1 cycle after its rx_valid.
    - sum = 8-bit sum of the data bytes.
    - After the last byte, respond 0x77, sum.
    - length 0: respond 0x77, 0x00 immediately, no rom_do_valid.
  - 8: 1 byte, overlay <= byte[0].
  - 9: 1 byte, report_mode <= byte[0] (0 = periodic only, 1 = periodic + on-change).
  - Any other opcode: ignored; stay in IDLE.
- RX FSM: IDLE -> PARAM -> (RESP_WAIT) -> IDLE.
  - RESP_WAIT is entered after commands 1, 2 and 7, and holds until the TX FSM finishes that response.
  - Any rx_valid while in RESP_WAIT: byte dropped, err_overrun pulses.
- Timeout:
  - In PARAM, a gap counter clears on each rx_valid.
  - When the counter reaches TIMEOUT: return to IDLE, pulse err_timeout, no response sent.
  - Partial core_config is discarded. ROM bytes already streamed stand.
- TX handshake:
  - tx_data must be stable while tx_valid && !tx_ready.
  - tx_valid deasserts only after an acceptance with no next byte.
  - Maximum throughput is 1 byte per cycle.
- TX arbitration:
  - Messages are atomic: once the first byte is accepted, the message completes.
  - At a message boundary, a pending response wins over a pending report.
- Joypad report:
  - Format: 0x01, then per pad (pad 0 first) JOY_BYTES bytes, LSB first.
  - The snapshot of joy is taken in the cycle the message starts.
  - Periodic trigger: free-running counter 0..REPORT_INTERVAL-1; at wrap, set report_due.
  - On-change trigger: when report_mode=1 and joy != last-sent snapshot, set report_due.
  - report_due clears when the report message starts. Multiple triggers while pending merge into one report.
- Reset mid-message: tx_valid drops on the next edge and the message is abandoned.

Test Plan:
- Core ID: send 0x01 with tx_ready tied 1 -> tx bytes 0x11, 0x01, 0x00; RX returns to IDLE.
- Backpressure on the string: send 0x02 with tx_ready toggled every other cycle -> "Tangcores" then 0x00 exactly once, tx_data stable while stalled.
- ROM load: send 0x07 00 00 03 10 20 F5 -> rom_do 0x10, 0x20, 0xF5 (three strobes), then tx 0x77, 0x25.
- Timeout: send 0x03 AA BB, then idle TIMEOUT cycles -> err_timeout pulses, core_config stays 0; a following 0x08 00 sets overlay=0.
- Reporting: report_mode=1, change joy[0] to 1 -> report 0x01 01 00 00 00 within a few cycles; no change -> next report only at the REPORT_INTERVAL wrap.
- Overrun/arbitration: a joypad report is in progress when 0x01 arrives -> report completes, then 0x11 response; an rx byte sent during RESP_WAIT pulses err_overrun.
